// File: rtl/sync_seeker_if.sv
// Gearbox-buffer to seeker-array bus: frame window in, lock status and offset out.
interface sync_seeker_if #(
   parameter int NUM_POS     = 66,
   parameter int NUM_SEEKERS = 4,
   parameter int BUF_W       = 194,
   parameter int POS_W       = (NUM_POS > 1) ? $clog2(NUM_POS) : 1,
   parameter int WIN_W       = (NUM_SEEKERS > 1) ? $clog2(NUM_SEEKERS) : 1
);
   logic [BUF_W-1:0]       gbox_buffer;
   logic                   buffer_dv;
   logic                   is_synced;
   logic [POS_W-1:0]       offset_pos;
   logic [WIN_W-1:0]       winner_idx;
   logic [NUM_SEEKERS-1:0] seeker_locked;
   logic                   lock_lost;

   modport master (
      output gbox_buffer, buffer_dv,
      input  is_synced, offset_pos, winner_idx, seeker_locked, lock_lost
   );

   modport slave (
      input  gbox_buffer, buffer_dv,
      output is_synced, offset_pos, winner_idx, seeker_locked, lock_lost
   );
endinterface

// File: rtl/sync_seeker_array.sv
// Parallel 64b/66b sync-header seeker: one hunt/lock FSM per offset slice plus a
// sticky arbiter choosing which slice reports offset and lock status.

module sync_seeker_lane #(
   parameter int BASE       = 0,
   parameter int LEN        = 1,
   parameter int POS_W      = 7,
   parameter int LOCK_CNT   = 32,
   parameter int WIN_LEN    = 64,
   parameter int UNLOCK_BAD = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [LEN:0]     hdr_bits,
   input  logic             dv,
   output logic             locked,
   output logic             locked_nxt,
   output logic [POS_W-1:0] pos_nxt
);
   localparam int GC_W = $clog2(LOCK_CNT + 1);
   localparam int FC_W = $clog2(WIN_LEN + 1);
   localparam int BC_W = $clog2(UNLOCK_BAD + 1);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t           state, state_d;
   logic [POS_W-1:0] pos, pos_adv;
   logic [GC_W-1:0]  good_cnt, good_d, good_inc;
   logic [FC_W-1:0]  frm_cnt, frm_d;
   logic [BC_W-1:0]  bad_cnt, bad_d, bad_inc;
   logic             hdr_ok;

   // hdr_bits is this slice's view, so offset BASE+i lives at bits [i+1:i]
   always_comb begin
      hdr_ok = 1'b0;
      for (int i = 0; i < LEN; i++)
         if (pos == POS_W'(BASE + i)) hdr_ok = hdr_bits[i] ^ hdr_bits[i+1];
   end

   assign pos_adv  = (pos == POS_W'(BASE + LEN - 1)) ? POS_W'(BASE) : pos + POS_W'(1);
   assign good_inc = good_cnt + GC_W'(1);
   assign bad_inc  = bad_cnt + BC_W'(!hdr_ok);

   always_comb begin
      state_d = state;
      pos_nxt = pos;
      good_d  = good_cnt;
      frm_d   = frm_cnt;
      bad_d   = bad_cnt;
      if (dv) begin
         case (state)
            SEARCH: begin
               if (hdr_ok) begin
                  good_d = good_inc;
                  if (good_inc == GC_W'(LOCK_CNT)) begin
                     state_d = LOCKED;
                     frm_d   = '0;
                     bad_d   = '0;
                  end
               end else begin
                  good_d  = '0;
                  pos_nxt = pos_adv;
               end
            end
            LOCKED: begin
               // unlock wins over a window end landing on the same frame
               if (bad_inc == BC_W'(UNLOCK_BAD)) begin
                  state_d = SEARCH;
                  pos_nxt = pos_adv;
                  good_d  = '0;
                  frm_d   = '0;
                  bad_d   = '0;
               end else if (frm_cnt == FC_W'(WIN_LEN - 1)) begin
                  frm_d = '0;
                  bad_d = '0;
               end else begin
                  frm_d = frm_cnt + FC_W'(1);
                  bad_d = bad_inc;
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= SEARCH;
         pos      <= POS_W'(BASE);
         good_cnt <= '0;
         frm_cnt  <= '0;
         bad_cnt  <= '0;
      end else begin
         state    <= state_d;
         pos      <= pos_nxt;
         good_cnt <= good_d;
         frm_cnt  <= frm_d;
         bad_cnt  <= bad_d;
      end
   end

   assign locked     = (state == LOCKED);
   assign locked_nxt = (state_d == LOCKED);
endmodule

module sync_seeker_array #(
   parameter int NUM_POS     = 66,
   parameter int NUM_SEEKERS = 4,
   parameter int BUF_W       = 194,
   parameter int LOCK_CNT    = 32,
   parameter int WIN_LEN     = 64,
   parameter int UNLOCK_BAD  = 16,
   parameter int POS_W       = (NUM_POS > 1) ? $clog2(NUM_POS) : 1
) (
   input logic          clk_i,
   input logic          rst_i,
   sync_seeker_if.slave bus
);
   localparam int WIN_W = (NUM_SEEKERS > 1) ? $clog2(NUM_SEEKERS) : 1;
   localparam int SL    = NUM_POS / NUM_SEEKERS;
   localparam int SR    = NUM_POS % NUM_SEEKERS;

   logic [NUM_SEEKERS-1:0]            lock_q, lock_d;
   logic [NUM_SEEKERS-1:0][POS_W-1:0] pos_d;
   logic [WIN_W-1:0]                  winner, win_d;
   logic [POS_W-1:0]                  offset_pos;
   logic                              is_synced, lock_lost;

   for (genvar k = 0; k < NUM_SEEKERS; k++) begin : g_seek
      localparam int LEN  = SL + ((k < SR) ? 1 : 0);
      localparam int BASE = k * SL + ((k < SR) ? k : SR);

      sync_seeker_lane #(
         .BASE(BASE), .LEN(LEN), .POS_W(POS_W),
         .LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .UNLOCK_BAD(UNLOCK_BAD)
      ) u_lane (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .hdr_bits   (bus.gbox_buffer[BASE+LEN:BASE]),
         .dv         (bus.buffer_dv),
         .locked     (lock_q[k]),
         .locked_nxt (lock_d[k]),
         .pos_nxt    (pos_d[k])
      );
   end

   if (BUF_W > NUM_POS + 1) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^bus.gbox_buffer[BUF_W-1:NUM_POS+1];
   end

   // Arbitrate on next-state lock flags so the outputs trail the deciding frame by one clk
   always_comb begin
      win_d = winner;
      if (!lock_d[winner])
         for (int k = NUM_SEEKERS - 1; k >= 0; k--)
            if (lock_d[k]) win_d = WIN_W'(k);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         winner     <= '0;
         is_synced  <= 1'b0;
         offset_pos <= '0;
         lock_lost  <= 1'b0;
      end else begin
         lock_lost <= 1'b0;
         if (bus.buffer_dv) begin
            winner     <= win_d;
            is_synced  <= lock_d[win_d];
            offset_pos <= pos_d[win_d];
            lock_lost  <= is_synced & ~lock_d[win_d];
         end
      end
   end

   assign bus.is_synced     = is_synced;
   assign bus.offset_pos    = offset_pos;
   assign bus.winner_idx    = winner;
   assign bus.seeker_locked = lock_q;
   assign bus.lock_lost     = lock_lost;
endmodule
